// File: rtl/dmem_lsu_if.sv
// Request/response and data-memory signal bundle for dmem_lsu.
// The slave modport is the LSU's view; master is the pipeline/memory side.
interface dmem_lsu_if #(
  parameter int DATA_W  = 32,
  parameter int LANE_W  = 4,
  parameter int MADDR_W = 16
) ();

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_uns;
  logic [31:0]        req_addr;
  logic [DATA_W-1:0]  req_wdata;

  logic               resp_valid;
  logic               resp_ready;
  logic [DATA_W-1:0]  resp_rdata;
  logic               resp_err;

  logic [MADDR_W-1:0] dmem_a;
  logic [DATA_W-1:0]  dmem_rd;
  logic [DATA_W-1:0]  dmem_wd;
  logic [LANE_W-1:0]  dmem_we;

  modport slave (
    input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    input  resp_ready, dmem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output dmem_a, dmem_wd, dmem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    output resp_ready, dmem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  dmem_a, dmem_wd, dmem_we
  );

endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a combinational-read data memory: lane steering,
// load extension, registered valid/ready response. LSU_ALIGN_EXC_EN enables alignment faults.
module dmem_lsu #(
  parameter int DATA_W  = 32,
  parameter int LANE_W  = 4,
  parameter int MADDR_W = 16
) (
  input logic        clk,
  input logic        rst,
  dmem_lsu_if.slave  bus
);

  localparam int OFF_W = $clog2(LANE_W);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2, SZ_ILL = 2'd3} size_e;

  state_e                   state_q, state_d;

  // Stage register: the request as captured at acceptance.
  logic                     we_q;
  logic                     uns_q;
  size_e                    size_q;
  logic [MADDR_W+OFF_W-1:0] addr_q;
  logic [DATA_W-1:0]        wdata_q;

  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic                     accept;
  logic                     in_access;
  logic                     fault;
  size_e                    eff_size;
  logic [OFF_W-1:0]         off;
  logic [DATA_W-1:0]        shifted;
  logic [LANE_W-1:0]        lane_we;
  logic [DATA_W-1:0]        lane_wd;
  logic [DATA_W-1:0]        load_ext;
  logic                     unused_addr_hi;

  // Address bits above the memory's reach simply wrap.
  assign unused_addr_hi = ^bus.req_addr[31:MADDR_W+OFF_W];

  assign bus.req_ready  = (state_q == IDLE) || (state_q == RESP && bus.resp_ready);
  assign accept         = bus.req_valid && bus.req_ready;
  assign in_access      = (state_q == ACCESS);

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.dmem_a     = addr_q[MADDR_W+OFF_W-1:OFF_W];

`ifdef LSU_ALIGN_EXC_EN
  assign fault    = (size_q == SZ_HALF && addr_q[0])
                 || (size_q == SZ_WORD && addr_q[OFF_W-1:0] != '0)
                 || (size_q == SZ_ILL);
  assign eff_size = size_q;
  assign off      = addr_q[OFF_W-1:0];
`else
  // Misaligned accesses are force-aligned; size 3 behaves as a word.
  assign fault    = 1'b0;
  assign eff_size = (size_q == SZ_ILL) ? SZ_WORD : size_q;
  assign off      = (eff_size == SZ_BYTE) ? addr_q[OFF_W-1:0]
                  : (eff_size == SZ_HALF) ? {addr_q[OFF_W-1:1], 1'b0}
                  : '0;
`endif

  assign shifted = bus.dmem_rd >> {off, 3'b000};

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lane_we  = '0;
    lane_wd  = '0;
    load_ext = '0;
    unique case (eff_size)
      SZ_BYTE: begin
        lane_we  = LANE_W'(1) << off;
        lane_wd  = {LANE_W{wdata_q[7:0]}};
        load_ext = uns_q ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                         : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        lane_we  = LANE_W'(3) << off;
        lane_wd  = {(LANE_W/2){wdata_q[15:0]}};
        load_ext = uns_q ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                         : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      end
      default: begin
        lane_we  = '1;
        lane_wd  = wdata_q;
        load_ext = shifted;
      end
    endcase
  end

  // Write enables are gated by reset so a store caught by reset never lands.
  assign bus.dmem_we = (in_access && we_q && !fault && !rst) ? lane_we : '0;
  assign bus.dmem_wd = (in_access && we_q && !fault) ? lane_wd : '0;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS: begin
        state_d = RESP;
        err_d   = fault;
        rdata_d = (we_q || fault) ? '0 : load_ext;
      end
      RESP:    if (bus.resp_ready) state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_uns;
        size_q  <= size_e'(bus.req_size);
        addr_q  <= bus.req_addr[MADDR_W+OFF_W-1:0];
        wdata_q <= bus.req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small byte-lane memory model behind it.
module tb_dmem_lsu;

  localparam int DATA_W  = 32;
  localparam int LANE_W  = 4;
  localparam int MADDR_W = 16;

  logic clk = 1'b0;
  logic rst;

  dmem_lsu_if #(.DATA_W(DATA_W), .LANE_W(LANE_W), .MADDR_W(MADDR_W)) bus ();

  dmem_lsu #(.DATA_W(DATA_W), .LANE_W(LANE_W), .MADDR_W(MADDR_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign bus.dmem_rd = mem[bus.dmem_a[7:0]];

  always @(posedge clk) begin
    for (int i = 0; i < LANE_W; i++)
      if (bus.dmem_we[i]) mem[bus.dmem_a[7:0]][8*i +: 8] <= bus.dmem_wd[8*i +: 8];
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  we_acc;
    logic [15:0] a_acc;
    logic [31:0] wd_acc;
    int          we_cnt;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } op_res_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with resp_ready high and collect what the unit did.
  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output op_res_t r);
    int n;
    r.we_acc = '0; r.a_acc = '0; r.wd_acc = '0; r.we_cnt = 0;
    r.lat = -1; r.rdata = '0; r.err = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size; bus.req_uns = uns;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.resp_ready = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 10) begin step(); n++; end
    if (!bus.req_ready) begin bus.req_valid = 1'b0; return; end
    step();
    bus.req_valid = 1'b0;
    r.we_acc = bus.dmem_we; r.a_acc = bus.dmem_a; r.wd_acc = bus.dmem_wd;
    n = 1;
    while (!bus.resp_valid && n < 10) begin
      if (bus.dmem_we != '0) r.we_cnt++;
      step(); n++;
    end
    if (bus.resp_valid) begin
      if (bus.dmem_we != '0) r.we_cnt++;
      r.lat = n; r.rdata = bus.resp_rdata; r.err = bus.resp_err;
    end
    step();
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_uns = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b exp 0", bus.resp_valid); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b exp 1", bus.req_ready); end
    total++; if (bus.dmem_we !== 4'h0) begin bad++; $display("FAIL reset_dmem_we: got %h exp 0", bus.dmem_we); end
    total++; if (bus.dmem_a !== 16'h0) begin bad++; $display("FAIL reset_dmem_a: got %h exp 0", bus.dmem_a); end
    total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h exp 0", bus.resp_rdata); end
    total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b exp 0", bus.resp_err); end
  endtask

  task automatic test_word();
    op_res_t r;
    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, r);
    total++; if (r.we_acc !== 4'hF) begin bad++; $display("FAIL sw_we: got %h exp f", r.we_acc); end
    total++; if (r.we_cnt !== 1) begin bad++; $display("FAIL sw_we_cycles: got %0d exp 1", r.we_cnt); end
    total++; if (r.a_acc !== 16'h0004) begin bad++; $display("FAIL sw_addr: got %h exp 0004", r.a_acc); end
    total++; if (r.wd_acc !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wd: got %h exp deadbeef", r.wd_acc); end
    total++; if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem: got %h exp deadbeef", mem[4]); end
    total++; if (r.rdata !== 32'h0) begin bad++; $display("FAIL sw_rdata: got %h exp 0", r.rdata); end
    total++; if (r.lat !== 2) begin bad++; $display("FAIL sw_latency: got %0d exp 2", r.lat); end
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r);
    total++; if (r.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data: got %h exp deadbeef", r.rdata); end
    total++; if (r.lat !== 2) begin bad++; $display("FAIL lw_latency: got %0d exp 2", r.lat); end
    total++; if (r.we_cnt !== 0) begin bad++; $display("FAIL lw_no_write: got %0d exp 0", r.we_cnt); end
  endtask

  task automatic test_byte_lanes();
    op_res_t r;
    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, r);
    do_op(1'b1, 2'd2, 1'b0, 32'h14, 32'h0, r);
    do_op(1'b1, 2'd0, 1'b0, 32'h13, 32'h123456A5, r);
    total++; if (r.we_acc !== 4'b1000) begin bad++; $display("FAIL sb_we: got %b exp 1000", r.we_acc); end
    total++; if (r.wd_acc !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wd: got %h exp a5a5a5a5", r.wd_acc); end
    total++; if (mem[4] !== 32'hA5000000) begin bad++; $display("FAIL sb_mem: got %h exp a5000000", mem[4]); end
    do_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, r);
    total++; if (r.rdata !== 32'hFFFFFFA5) begin bad++; $display("FAIL lb_sign: got %h exp ffffffa5", r.rdata); end
    do_op(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, r);
    total++; if (r.rdata !== 32'h000000A5) begin bad++; $display("FAIL lbu_zero: got %h exp 000000a5", r.rdata); end
    do_op(1'b1, 2'd1, 1'b0, 32'h16, 32'hFFFF1234, r);
    total++; if (r.we_acc !== 4'b1100) begin bad++; $display("FAIL sh_we: got %b exp 1100", r.we_acc); end
    total++; if (r.wd_acc !== 32'h12341234) begin bad++; $display("FAIL sh_wd: got %h exp 12341234", r.wd_acc); end
    total++; if (mem[5] !== 32'h12340000) begin bad++; $display("FAIL sh_mem: got %h exp 12340000", mem[5]); end
  endtask

  task automatic test_half_sign();
    op_res_t r;
    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h80017FFF, r);
    do_op(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, r);
    total++; if (r.rdata !== 32'h00007FFF) begin bad++; $display("FAIL lh_lo: got %h exp 00007fff", r.rdata); end
    do_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, r);
    total++; if (r.rdata !== 32'hFFFF8001) begin bad++; $display("FAIL lh_hi: got %h exp ffff8001", r.rdata); end
    do_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, r);
    total++; if (r.rdata !== 32'h00008001) begin bad++; $display("FAIL lhu_hi: got %h exp 00008001", r.rdata); end
    do_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, r);
    total++; if (r.rdata !== 32'h0000007F) begin bad++; $display("FAIL lb_lane1: got %h exp 0000007f", r.rdata); end
    do_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, r);
    total++; if (r.rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_lane3: got %h exp ffffff80", r.rdata); end
  endtask

  // Expects mem[4] = 0x80017FFF from the previous scenario.
  task automatic test_back_to_back();
    bus.resp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_we = 1'b0;
    bus.req_size = 2'd2; bus.req_uns = 1'b0; bus.req_addr = 32'h10;
    step();
    bus.req_valid = 1'b0;
    step();
    total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid: got %b exp 1", bus.resp_valid); end
    total++; if (bus.resp_rdata !== 32'h80017FFF) begin bad++; $display("FAIL bp_first_data: got %h exp 80017fff", bus.resp_rdata); end
    bus.req_valid = 1'b1; bus.req_size = 2'd1; bus.req_addr = 32'h12;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b exp 1", i, bus.resp_valid); end
      total++; if (bus.resp_rdata !== 32'h80017FFF) begin bad++; $display("FAIL bp_hold_data[%0d]: got %h exp 80017fff", i, bus.resp_rdata); end
      total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready[%0d]: got %b exp 0", i, bus.req_ready); end
    end
    bus.resp_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b exp 1", bus.req_ready); end
    step();
    bus.req_valid = 1'b0;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_access_valid: got %b exp 0", bus.resp_valid); end
    step();
    total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL b2b_resp_valid: got %b exp 1", bus.resp_valid); end
    total++; if (bus.resp_rdata !== 32'hFFFF8001) begin bad++; $display("FAIL b2b_data: got %h exp ffff8001", bus.resp_rdata); end
    step();
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b exp 0", bus.resp_valid); end
  endtask

  task automatic test_misalign();
    op_res_t r;
    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h11111111, r);
    do_op(1'b1, 2'd2, 1'b0, 32'h11, 32'hCAFEF00D, r);
`ifdef LSU_ALIGN_EXC_EN
    total++; if (r.err !== 1'b1) begin bad++; $display("FAIL mis_sw_err: got %b exp 1", r.err); end
    total++; if (r.we_cnt !== 0) begin bad++; $display("FAIL mis_sw_we_cycles: got %0d exp 0", r.we_cnt); end
    total++; if (mem[4] !== 32'h11111111) begin bad++; $display("FAIL mis_sw_mem: got %h exp 11111111", mem[4]); end
    do_op(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, r);
    total++; if (r.err !== 1'b1 || r.rdata !== 32'h0) begin bad++; $display("FAIL mis_lh: got err=%b data=%h exp err=1 data=0", r.err, r.rdata); end
    do_op(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, r);
    total++; if (r.err !== 1'b1 || r.rdata !== 32'h0) begin bad++; $display("FAIL size3: got err=%b data=%h exp err=1 data=0", r.err, r.rdata); end
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r);
    total++; if (r.err !== 1'b0 || r.rdata !== 32'h11111111) begin bad++; $display("FAIL mis_recover: got err=%b data=%h exp err=0 data=11111111", r.err, r.rdata); end
`else
    total++; if (r.err !== 1'b0) begin bad++; $display("FAIL mis_sw_err: got %b exp 0", r.err); end
    total++; if (r.we_acc !== 4'hF || r.a_acc !== 16'h0004) begin bad++; $display("FAIL mis_sw_lanes: got we=%h a=%h exp we=f a=0004", r.we_acc, r.a_acc); end
    total++; if (mem[4] !== 32'hCAFEF00D) begin bad++; $display("FAIL mis_sw_mem: got %h exp cafef00d", mem[4]); end
    do_op(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, r);
    total++; if (r.err !== 1'b0 || r.rdata !== 32'hFFFFCAFE) begin bad++; $display("FAIL mis_lh: got err=%b data=%h exp err=0 data=ffffcafe", r.err, r.rdata); end
    do_op(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, r);
    total++; if (r.err !== 1'b0 || r.rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL size3: got err=%b data=%h exp err=0 data=cafef00d", r.err, r.rdata); end
    do_op(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, r);
    total++; if (r.rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL mis_lw: got %h exp cafef00d", r.rdata); end
`endif
  endtask

  task automatic test_reset_mid_op();
    op_res_t r;
    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, r);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_uns = 1'b0;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h5A; bus.resp_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    total++; if (bus.dmem_we !== 4'b0001) begin bad++; $display("FAIL rst_pre_we: got %b exp 0001", bus.dmem_we); end
    rst = 1'b1;
    #1;
    total++; if (bus.dmem_we !== 4'b0000) begin bad++; $display("FAIL rst_gate_we: got %b exp 0000", bus.dmem_we); end
    step();
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b exp 0", bus.resp_valid); end
    total++; if (mem[4] !== 32'h0) begin bad++; $display("FAIL rst_mem: got %h exp 0", mem[4]); end
    rst = 1'b0;
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b exp 1", bus.req_ready); end
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r);
    total++; if (r.rdata !== 32'h0 || r.lat !== 2) begin bad++; $display("FAIL rst_after_load: got data=%h lat=%0d exp data=0 lat=2", r.rdata, r.lat); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_half_sign();
    test_back_to_back();
    test_misalign();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
